// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_stage_hs #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;

  // The skid variant exposes only the registered ready; the single-register variant passes out_ready through.
  assign in_ready  = (SKID != 0) ? in_ready_q : ((state_q == EMPTY) || out_ready);
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    accept   = in_valid && in_ready;
    emit     = out_valid && out_ready;
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    stall_d  = stall_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end
      end
      ONE: begin
        if (accept && emit) begin
          m_ctrl_d = in_ctrl;
          m_data_d = in_data;
        end else if (accept) begin
          state_d  = FULL;
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
        end else if (emit) begin
          state_d  = EMPTY;
          m_ctrl_d = '0;
        end
      end
      FULL: begin
        if (emit) begin
          state_d  = ONE;
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
          s_ctrl_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush squashes everything, including an entry accepted this same cycle.
    if (flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end
    in_ready_d = (state_d != FULL);
    if (out_valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      m_ctrl_q   <= '0;
      m_data_q   <= '0;
      s_ctrl_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      m_ctrl_q   <= m_ctrl_d;
      m_data_q   <= m_data_d;
      s_ctrl_q   <= s_ctrl_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - self-checking bench for pipe_stage_hs, SKID=1 and SKID=0 instances
module tb_pipe_stage_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [63:0] in_data;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [15:0] out_ctrl1, out_ctrl0;
  logic [63:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  stall1, stall0;

  pipe_stage_hs #(.CTRL_W(16), .DATA_W(64), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1), .stall_cnt(stall1));

  pipe_stage_hs #(.CTRL_W(16), .DATA_W(64), .SKID(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0), .stall_cnt(stall0));

  typedef struct packed {
    logic [15:0] c;
    logic [63:0] d;
  } ent_t;

  ent_t        q1[$], q0[$];
  logic [15:0] log1[$];
  int          sc1, sc0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0), evaluated once per cycle.
  logic        v, r;
  logic [15:0] ec;
  ent_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      q1.delete(); q0.delete(); sc1 = 0; sc0 = 0;
      chk("rst_valid1", out_valid1, 0); chk("rst_ready1", in_ready1, 1);
      chk("rst_occ1", occ1, 0); chk("rst_ctrl1", out_ctrl1, 0); chk("rst_stall1", stall1, 0);
      chk("rst_valid0", out_valid0, 0); chk("rst_ready0", in_ready0, 1);
      chk("rst_occ0", occ0, 0); chk("rst_ctrl0", out_ctrl0, 0); chk("rst_stall0", stall0, 0);
    end else begin
      e.c = in_ctrl;
      e.d = in_data;
      v  = q1.size() > 0;
      r  = q1.size() < 2;
      ec = 16'h0;
      if (v) ec = q1[0].c;
      chk("s1_out_valid", out_valid1, v);
      chk("s1_in_ready", in_ready1, r);
      chk("s1_occ", occ1, q1.size());
      chk("s1_out_ctrl", out_ctrl1, ec);
      if (v) chk("s1_out_data", out_data1, q1[0].d);
      chk("s1_stall", stall1, sc1);
      if (v && !out_ready && sc1 < 15) sc1++;
      if (flush) q1.delete();
      else begin
        if (v && out_ready) begin
          log1.push_back(q1[0].c);
          void'(q1.pop_front());
        end
        if (in_valid && r) q1.push_back(e);
      end

      v  = q0.size() > 0;
      r  = (q0.size() == 0) || out_ready;
      ec = 16'h0;
      if (v) ec = q0[0].c;
      chk("s0_out_valid", out_valid0, v);
      chk("s0_in_ready", in_ready0, r);
      chk("s0_occ", occ0, q0.size());
      chk("s0_out_ctrl", out_ctrl0, ec);
      if (v) chk("s0_out_data", out_data0, q0[0].d);
      chk("s0_stall", stall0, sc0);
      if (v && !out_ready && sc0 < 15) sc0++;
      if (flush) q0.delete();
      else begin
        if (v && out_ready) void'(q0.pop_front());
        if (in_valid && r) q0.push_back(e);
      end
    end
  end

  task automatic drive(input logic vi, input logic [15:0] c, input logic ordy, input logic fl);
    in_valid  = vi;
    in_ctrl   = c;
    in_data   = {$urandom, $urandom};
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle_valid", out_valid1, 0); chk("idle_occ", occ1, 0); chk("idle_ctrl", out_ctrl1, 0);

    log1.delete();
    for (int i = 1; i <= 10; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("stream_count", log1.size(), 10);
    if (log1.size() == 10) for (int i = 0; i < 10; i++) chk("stream_order", log1[i], 16'(i + 1));
    chk("stream_stall", stall1, 0);

    log1.delete();
    drive(1'b1, 16'h000A, 1'b0, 1'b0);
    drive(1'b1, 16'h000B, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 16'h000C, 1'b0, 1'b0);
    chk("skid_occ", occ1, 2); chk("skid_ready", in_ready1, 0);
    chk("skid_ctrl", out_ctrl1, 16'h000A); chk("skid_stall", stall1, 4);
    repeat (2) drive(1'b1, 16'h000C, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("skid_count", log1.size(), 3);
    if (log1.size() == 3) begin
      chk("skid_a", log1[0], 16'h000A); chk("skid_b", log1[1], 16'h000B); chk("skid_c", log1[2], 16'h000C);
    end

    log1.delete();
    drive(1'b1, 16'h00F1, 1'b0, 1'b0);
    drive(1'b1, 16'h00F2, 1'b0, 1'b0);
    chk("flush_pre_occ", occ1, 2);
    drive(1'b1, 16'h000D, 1'b0, 1'b1);
    chk("flush_occ", occ1, 0); chk("flush_valid", out_valid1, 0); chk("flush_ctrl", out_ctrl1, 0);
    drive(1'b1, 16'h000E, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("flush_count", log1.size(), 1);
    if (log1.size() == 1) chk("flush_e", log1[0], 16'h000E);

    drive(1'b1, 16'h0051, 1'b0, 1'b0);
    drive(1'b1, 16'h0052, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat_value", stall1, 15);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("sat_after_flush", stall1, 15); chk("sat_flush_occ", occ1, 0);
    drive(1'b1, 16'h0061, 1'b0, 1'b0);
    drive(1'b1, 16'h0062, 1'b0, 1'b0);
    chk("arst_pre_occ", occ1, 2);
    rst = 1'b0;
    #1;
    chk("arst_occ", occ1, 0); chk("arst_valid", out_valid1, 0); chk("arst_ready", in_ready1, 1);
    chk("arst_stall", stall1, 0); chk("arst_ctrl", out_ctrl1, 0); chk("arst_data", out_data1, 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post_rst_occ", occ1, 0); chk("post_rst_ctrl", out_ctrl1, 0);

    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_ctrl = 16'(16'h100 + i); in_data = {$urandom, $urandom};
      out_ready = (i % 2 == 0); flush = 1'b0;
      #1;
      if (out_valid0) chk("s0_ready_eq_oready", in_ready0, out_ready);
      chk("s0_occ_max", occ0 <= 2'd1, 1);
      @(posedge clk);
      #2;
    end
    repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

    repeat (400) drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
                       $urandom_range(0, 19) == 0);
    repeat (3) drive(1'b0, 16'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control bundle and one data bundle between stages using a valid/ready handshake. Supports stall and flush.
- Optional 2-entry skid buffer, so upstream ready is a registered signal.
- One instance replaces each hand-wired dff-array stage register; control fields read as zero (NOP) whenever the stage holds no valid entry.

Parameters:
- CTRL_W, 16, width of control bundle (ALU op, dst, mem/reg-write enables, halt, ...); zeroed on bubble/flush.
- DATA_W, 64, width of data bundle (instruction, immediate, operands, register numbers); not zeroed, holds last value.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held entries (branch mispredict / exception).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control bundle; 0 when out_valid=0.
- out_data  out  DATA_W  data bundle; meaningful only when out_valid=1.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Transfers:
  - Accept when in_valid && in_ready.
  - Emit when out_valid && out_ready.
  - Both are evaluated on the same rising edge.
- Reset (rst=0, asynchronous): all valids 0, all ctrl/data registers 0, occupancy 0, stall_cnt 0. in_ready=1 while reset is asserted and on the first cycle after.
- Latency: 1 cycle; data accepted at edge N appears on out_* after edge N.
- Throughput: 1 entry/cycle with no stall, for both SKID values.
- SKID=1 state machine (main reg M, skid reg S):
  - EMPTY (occ 0): accept -> ONE (entry into M).
  - ONE (occ 1):
    - accept && emit -> ONE (M <= in).
    - accept && !emit -> FULL (S <= in).
    - emit && !accept -> EMPTY.
    - Otherwise hold.
  - FULL (occ 2): in_ready=0.
    - emit -> ONE (M <= S).
    - Otherwise hold.
  - in_ready = (state != FULL), driven from a register only, with no combinational path from out_ready.
  - out_* always driven from M; order is strictly FIFO.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept loads M; emit without accept clears valid.
- Flush:
  - Next state EMPTY; all valids cleared; ctrl registers zeroed.
  - An entry offered in the same cycle is dropped, even if accepted (flush wins).
  - in_ready is unaffected in the flush cycle, so upstream sees a normal handshake.
- Bubble gating:
  - out_ctrl = M.ctrl when out_valid, else 0.
  - The ctrl register is also written 0 on emit-without-accept.
  - out_data is not gated; it holds its last value.
- Stall hold: with out_valid=1 and out_ready=0, out_ctrl/out_data are stable and bit-identical every cycle until emit or flush.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst; flush does not clear it.
- X-safety: in_ctrl/in_data are ignored when in_valid=0 and never captured.

Test Plan:
- Reset/idle: rst=0 mid-stream with occ=2 -> all outputs 0 at once (asynchronous), in_ready=1; release; in_valid=0 for 5 cycles -> out_valid=0, out_ctrl=0, occ=0.
- Streaming: SKID=1, out_ready=1, push ctrl=1..10 back-to-back -> out_ctrl 1..10 on consecutive cycles, 1-cycle latency, in_ready always 1, stall_cnt=0.
- Stall/skid:
  - Push A, B, C with out_ready=0 -> occ=2 after B; in_ready=0; C held off; out_ctrl=A stable; stall_cnt increments each cycle.
  - Raise out_ready -> emits A, B, C in order with no loss or duplication.
- Flush:
  - FULL state, flush=1 with in_valid=1 (D offered) -> next cycle occ=0, out_valid=0, out_ctrl=0; D is never emitted.
  - Next push E -> emitted normally.
- Saturation: CNT_W=4, hold stall 20 cycles -> stall_cnt=15 and stays 15; flush does not clear it; rst does.
- SKID=0 variant: out_ready toggling 1,0,1,0 with continuous input -> in_ready equals out_ready whenever out_valid=1; order preserved; occ never exceeds 1.
